// File: rtl/ec_fe6_mnr_s_if.sv
// BLS12-381 modulus package and the valid/ready stream interface used by ec_fe6_mnr_s.
// The package comes first so the design's default modulus resolves when the files are compiled in order.
package bls12_381_pkg;
    localparam logic [380:0] P = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
endpackage

interface if_axi_stream #(
    parameter int DAT_BITS = 381,
    parameter int CTL_BITS = 12
) ();
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;

    modport source (output val, sop, eop, dat, ctl, input rdy);
    modport sink   (input val, sop, eop, dat, ctl, output rdy);
endinterface

// File: rtl/ec_fe6_mnr_s.sv
// Streamed Fp6 multiply-by-non-residue (v * a) for BLS12-381: collects 6 beats, emits 6 beats.
// Optional sop/eop framing checker with sticky o_err: define EC_FE6_MNR_PROTOCOL_CHK_EN.
module ec_fe6_mnr_s #(
    parameter type FE_TYPE = logic [380:0],
    parameter logic [$bits(FE_TYPE)-1:0] P = bls12_381_pkg::P,
    parameter int CTL_BITS = 12
) (
    input  logic           i_clk,
    input  logic           i_rst,
    if_axi_stream.sink     i_mnr_fe6_if,
    if_axi_stream.source   o_mnr_fe6_if
`ifdef EC_FE6_MNR_PROTOCOL_CHK_EN
    ,
    output logic           o_err
`endif
);
    localparam int DAT_BITS = $bits(FE_TYPE);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] EMIT    = 1'b1;

    logic [0:0]          state;
    logic [2:0]          in_cnt;
    logic [2:0]          out_cnt;
    logic [2:0]          nxt_cnt;
    logic [2:0]          wr_idx;
    logic [CTL_BITS-1:0] ctl_q;
    logic [DAT_BITS-1:0] buf_q [6];

    logic                in_acc;
    logic                out_acc;
    logic                resync;
    logic [DAT_BITS:0]   sum_w;
    logic [DAT_BITS:0]   dif_w;
    logic [DAT_BITS-1:0] add_res;
    logic [DAT_BITS-1:0] sub_res;
    logic [DAT_BITS-1:0] nxt_dat;

    assign i_mnr_fe6_if.rdy = (state == COLLECT);
    assign in_acc  = i_mnr_fe6_if.val && i_mnr_fe6_if.rdy;
    assign out_acc = o_mnr_fe6_if.val && o_mnr_fe6_if.rdy;
    assign nxt_cnt = out_cnt + 3'd1;

`ifdef EC_FE6_MNR_PROTOCOL_CHK_EN
    logic frame_err;
    assign resync    = i_mnr_fe6_if.sop && (in_cnt != 3'd0);
    assign frame_err = (i_mnr_fe6_if.sop != (in_cnt == 3'd0)) ||
                       (i_mnr_fe6_if.eop != (in_cnt == 3'd5));
`else
    assign resync = 1'b0;
`endif

    // A stray sop restarts the packet: that beat becomes beat 0.
    assign wr_idx = resync ? 3'd0 : in_cnt;

    // xi * c2 with c2.c0 already buffered and c2.c1 arriving on the current beat.
    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    always_comb begin
        sum_w   = {1'b0, buf_q[4]} + {1'b0, i_mnr_fe6_if.dat};
        dif_w   = {1'b0, buf_q[4]} - {1'b0, i_mnr_fe6_if.dat};
        add_res = (sum_w >= {1'b0, P}) ? DAT_BITS'(sum_w - {1'b0, P}) : sum_w[DAT_BITS-1:0];
        sub_res = dif_w[DAT_BITS] ? DAT_BITS'(dif_w[DAT_BITS-1:0] + P) : dif_w[DAT_BITS-1:0];
    end

    // Output order after beat 0: xi*c2.c1, c0.c0, c0.c1, c1.c0, c1.c1.
    always_comb begin
        nxt_dat = buf_q[5];
        case (nxt_cnt)
            3'd2:    nxt_dat = buf_q[0];
            3'd3:    nxt_dat = buf_q[1];
            3'd4:    nxt_dat = buf_q[2];
            3'd5:    nxt_dat = buf_q[3];
            default: nxt_dat = buf_q[5];
        endcase
    end

    // NOTE: the operand buffer has no reset; every entry is rewritten before it is read.
    always_ff @(posedge i_clk) begin
        if (in_acc) begin
            if (wr_idx == 3'd5) begin
                buf_q[4] <= sub_res;
                buf_q[5] <= add_res;
            end else begin
                buf_q[wr_idx] <= i_mnr_fe6_if.dat;
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= COLLECT;
            in_cnt           <= 3'd0;
            out_cnt          <= 3'd0;
            ctl_q            <= '0;
            o_mnr_fe6_if.val <= 1'b0;
            o_mnr_fe6_if.sop <= 1'b0;
            o_mnr_fe6_if.eop <= 1'b0;
            o_mnr_fe6_if.dat <= '0;
            o_mnr_fe6_if.ctl <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_acc) begin
                        if (wr_idx == 3'd0) ctl_q <= i_mnr_fe6_if.ctl;
                        if (wr_idx == 3'd5) begin
                            // Beat 0 is loaded straight from the adder path to save a cycle.
                            in_cnt           <= 3'd0;
                            out_cnt          <= 3'd0;
                            state            <= EMIT;
                            o_mnr_fe6_if.val <= 1'b1;
                            o_mnr_fe6_if.sop <= 1'b1;
                            o_mnr_fe6_if.eop <= 1'b0;
                            o_mnr_fe6_if.dat <= sub_res;
                            o_mnr_fe6_if.ctl <= ctl_q;
                        end else begin
                            in_cnt <= wr_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    if (out_acc) begin
                        if (out_cnt == 3'd5) begin
                            state            <= COLLECT;
                            out_cnt          <= 3'd0;
                            o_mnr_fe6_if.val <= 1'b0;
                            o_mnr_fe6_if.sop <= 1'b0;
                            o_mnr_fe6_if.eop <= 1'b0;
                        end else begin
                            out_cnt          <= nxt_cnt;
                            o_mnr_fe6_if.sop <= 1'b0;
                            o_mnr_fe6_if.eop <= (nxt_cnt == 3'd5);
                            o_mnr_fe6_if.dat <= nxt_dat;
                        end
                    end
                end
            endcase
        end
    end

`ifdef EC_FE6_MNR_PROTOCOL_CHK_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                      o_err <= 1'b0;
        else if (in_acc && frame_err)   o_err <= 1'b1;
    end
`endif

endmodule
